// File: rtl/race_light_sequencer.sv
//------------------------------------------------------------------------------
// race_light_sequencer
//
// Parametrised multi-lane race start-light controller. After Start it runs
// RED -> YELLOW -> GREEN, each phase held for a parameter-set number of clocks,
// then returns to IDLE with a one-clock Done pulse. Lane motion during RED or
// YELLOW is a false start: the sequence drops into FAULT and the offending
// lanes are latched in False_Start. Abort cancels any running sequence and is
// the only way out of FAULT.
//
// All state changes happen on the falling edge of Clk.
//
// Optional feature (compile-time macro RLS_FAULT_BLINK_EN):
//   defined   - Red blinks in FAULT (1 on the entry edge, then toggles)
//   undefined - Red is steady in FAULT
//
// Ports:
//   Clk          in   1          sequencing tick, active on negedge
//   nReset       in   1          asynchronous, active-low reset
//   Start        in   1          begin sequence (sampled only in IDLE)
//   Abort        in   1          cancel sequence / leave FAULT
//   Lane_Move    in   NUM_LANES  per-lane motion sensors, active-high
//   Red          out  1          red lamp
//   Yellow       out  1          yellow lamp
//   Green        out  1          green lamp
//   Busy         out  1          high in RED, YEL, GRN
//   Done         out  1          registered pulse after GRN completes
//   Fault        out  1          high in FAULT
//   False_Start  out  NUM_LANES  sticky per-lane false-start flags
//------------------------------------------------------------------------------
module race_light_sequencer #(
   parameter int NUM_LANES = 4,
   parameter int CNT_W     = 4,
   parameter int RED_TICKS = 2,
   parameter int YEL_TICKS = 2,
   parameter int GRN_TICKS = 6
) (
   input  logic                 Clk,
   input  logic                 nReset,
   input  logic                 Start,
   input  logic                 Abort,
   input  logic [NUM_LANES-1:0] Lane_Move,
   output logic                 Red,
   output logic                 Yellow,
   output logic                 Green,
   output logic                 Busy,
   output logic                 Done,
   output logic                 Fault,
   output logic [NUM_LANES-1:0] False_Start
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RED   = 3'd1;
   localparam logic [2:0] S_YEL   = 3'd2;
   localparam logic [2:0] S_GRN   = 3'd3;
   localparam logic [2:0] S_FAULT = 3'd4;

   // Counter reload values: a phase lasts exactly <PHASE>_TICKS clocks
   // because it exits on the edge where the counter reads zero.
   localparam logic [CNT_W-1:0] RED_LD = CNT_W'(RED_TICKS - 1);
   localparam logic [CNT_W-1:0] YEL_LD = CNT_W'(YEL_TICKS - 1);
   localparam logic [CNT_W-1:0] GRN_LD = CNT_W'(GRN_TICKS - 1);

   logic [2:0]           state, state_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt, cnt_dec;
   logic [NUM_LANES-1:0] fs_nxt;
   logic                 done_nxt;
   logic                 lane_any;
   logic                 cnt_zero;

   assign cnt_dec  = cnt - CNT_W'(1);
   assign cnt_zero = (cnt == '0);
   assign lane_any = |Lane_Move;

   // Next-state logic. Abort outranks false-start detection, which outranks
   // normal phase expiry; IDLE ignores Abort and Lane_Move entirely.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      fs_nxt    = False_Start;
      done_nxt  = 1'b0;
      case (state)
         S_IDLE: begin
            if (Start) begin
               state_nxt = S_RED;
               cnt_nxt   = RED_LD;
               fs_nxt    = '0;
            end
         end
         S_RED: begin
            if (Abort) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end else if (lane_any) begin
               state_nxt = S_FAULT;
               cnt_nxt   = '0;
               fs_nxt    = False_Start | Lane_Move;
            end else if (cnt_zero) begin
               state_nxt = S_YEL;
               cnt_nxt   = YEL_LD;
            end else begin
               cnt_nxt   = cnt_dec;
            end
         end
         S_YEL: begin
            if (Abort) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end else if (lane_any) begin
               state_nxt = S_FAULT;
               cnt_nxt   = '0;
               fs_nxt    = False_Start | Lane_Move;
            end else if (cnt_zero) begin
               state_nxt = S_GRN;
               cnt_nxt   = GRN_LD;
            end else begin
               cnt_nxt   = cnt_dec;
            end
         end
         S_GRN: begin
            if (Abort) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end else if (cnt_zero) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
               done_nxt  = 1'b1;
            end else begin
               cnt_nxt   = cnt_dec;
            end
         end
         S_FAULT: begin
            if (Abort) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end
         end
         default: begin
            // Unreachable encodings recover to IDLE on the next edge.
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(negedge Clk or negedge nReset) begin
      if (!nReset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         False_Start <= '0;
         Done        <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         False_Start <= fs_nxt;
         Done        <= done_nxt;
      end
   end

`ifdef RLS_FAULT_BLINK_EN
   logic blink;

   // Forced to 1 whenever the next state is not a continuing FAULT, so the
   // entry edge always shows Red lit before toggling begins.
   always_ff @(negedge Clk or negedge nReset) begin
      if (!nReset) begin
         blink <= 1'b1;
      end else if (state == S_FAULT && state_nxt == S_FAULT) begin
         blink <= ~blink;
      end else begin
         blink <= 1'b1;
      end
   end
`endif

   // Moore lamp decode.
   always_comb begin
      Red    = 1'b0;
      Yellow = 1'b0;
      Green  = 1'b0;
      Busy   = 1'b0;
      Fault  = 1'b0;
      case (state)
         S_RED: begin
            Red  = 1'b1;
            Busy = 1'b1;
         end
         S_YEL: begin
            Yellow = 1'b1;
            Busy   = 1'b1;
         end
         S_GRN: begin
            Green = 1'b1;
            Busy  = 1'b1;
         end
         S_FAULT: begin
`ifdef RLS_FAULT_BLINK_EN
            Red   = blink;
`else
            Red   = 1'b1;
`endif
            Fault = 1'b1;
         end
         default: begin
            Red = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_race_light_sequencer.sv
//------------------------------------------------------------------------------
// tb_race_light_sequencer
//
// Directed self-checking bench. dut drives default parameters; dut2 uses the
// 1/16/1 phase configuration and shares the same inputs. Outputs are sampled
// 1 time unit after each falling clock edge; inputs change at the same point.
// Observed lamp/status vectors are packed as {Red,Yellow,Green,Busy,Done,Fault}.
//------------------------------------------------------------------------------
module tb_race_light_sequencer;

   logic       Clk;
   logic       nReset;
   logic       Start;
   logic       Abort;
   logic [3:0] Lane_Move;

   logic       Red, Yellow, Green, Busy, Done, Fault;
   logic [3:0] False_Start;
   logic       Red2, Yellow2, Green2, Busy2, Done2, Fault2;
   logic [3:0] False_Start2;

   int n_checks = 0;
   int n_fail   = 0;

   race_light_sequencer dut (
      .Clk         (Clk),
      .nReset      (nReset),
      .Start       (Start),
      .Abort       (Abort),
      .Lane_Move   (Lane_Move),
      .Red         (Red),
      .Yellow      (Yellow),
      .Green       (Green),
      .Busy        (Busy),
      .Done        (Done),
      .Fault       (Fault),
      .False_Start (False_Start)
   );

   race_light_sequencer #(
      .NUM_LANES (4),
      .CNT_W     (4),
      .RED_TICKS (1),
      .YEL_TICKS (16),
      .GRN_TICKS (1)
   ) dut2 (
      .Clk         (Clk),
      .nReset      (nReset),
      .Start       (Start),
      .Abort       (Abort),
      .Lane_Move   (Lane_Move),
      .Red         (Red2),
      .Yellow      (Yellow2),
      .Green       (Green2),
      .Busy        (Busy2),
      .Done        (Done2),
      .Fault       (Fault2),
      .False_Start (False_Start2)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   localparam logic [5:0] V_IDLE = 6'b100000;
   localparam logic [5:0] V_RED  = 6'b100100;
   localparam logic [5:0] V_YEL  = 6'b010100;
   localparam logic [5:0] V_GRN  = 6'b001100;
   localparam logic [5:0] V_DONE = 6'b100010;

   task automatic tick();
      @(negedge Clk);
      #1;
   endtask

   task automatic test_reset();
      logic [5:0] obs;
      nReset = 1'b1; Start = 1'b0; Abort = 1'b0; Lane_Move = '0;
      #2 nReset = 1'b0;
      #1;
      obs = {Red, Yellow, Green, Busy, Done, Fault};
      n_checks++;
      if (obs !== V_IDLE) begin
         n_fail++; $display("FAIL reset_outputs: got %b expected %b", obs, V_IDLE);
      end
      n_checks++;
      if (False_Start !== 4'b0000) begin
         n_fail++; $display("FAIL reset_flags: got %b expected 0000", False_Start);
      end
      tick();
      nReset = 1'b1;
      tick();
      obs = {Red, Yellow, Green, Busy, Done, Fault};
      n_checks++;
      if (obs !== V_IDLE) begin
         n_fail++; $display("FAIL reset_idle_hold: got %b expected %b", obs, V_IDLE);
      end
   endtask

   task automatic test_params();
      logic [5:0] obs, exp;
      Start = 1'b1; tick(); Start = 1'b0;
      for (int i = 0; i < 18; i++) begin
         exp = (i == 0) ? V_RED : (i <= 16) ? V_YEL : V_GRN;
         obs = {Red2, Yellow2, Green2, Busy2, Done2, Fault2};
         n_checks++;
         if (obs !== exp) begin
            n_fail++; $display("FAIL params_phase[%0d]: got %b expected %b", i, obs, exp);
         end
         tick();
      end
      obs = {Red2, Yellow2, Green2, Busy2, Done2, Fault2};
      n_checks++;
      if (obs !== V_DONE) begin
         n_fail++; $display("FAIL params_done: got %b expected %b", obs, V_DONE);
      end
      tick();
   endtask

   task automatic test_normal();
      logic [5:0] obs, exp;
      int busy_cnt;
      busy_cnt = 0;
      Start = 1'b1; tick(); Start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         exp = (i < 2) ? V_RED : (i < 4) ? V_YEL : V_GRN;
         obs = {Red, Yellow, Green, Busy, Done, Fault};
         if (Busy === 1'b1) busy_cnt++;
         n_checks++;
         if (obs !== exp) begin
            n_fail++; $display("FAIL normal_phase[%0d]: got %b expected %b", i, obs, exp);
         end
         tick();
      end
      obs = {Red, Yellow, Green, Busy, Done, Fault};
      n_checks++;
      if (obs !== V_DONE) begin
         n_fail++; $display("FAIL normal_done: got %b expected %b", obs, V_DONE);
      end
      tick();
      obs = {Red, Yellow, Green, Busy, Done, Fault};
      n_checks++;
      if (obs !== V_IDLE) begin
         n_fail++; $display("FAIL normal_done_clear: got %b expected %b", obs, V_IDLE);
      end
      n_checks++;
      if (busy_cnt != 10) begin
         n_fail++; $display("FAIL normal_busy_len: got %0d expected 10", busy_cnt);
      end
   endtask

   task automatic test_false_start();
      logic [5:0] obs;
      logic       exp_red;
      Start = 1'b1; tick(); Start = 1'b0;
      tick(); tick(); tick();            // now in 2nd YEL clock
      Lane_Move = 4'b0100;
      tick();
      Lane_Move = 4'b0000;
      Start = 1'b1;                      // must be ignored in FAULT
      for (int i = 0; i < 20; i++) begin
`ifdef RLS_FAULT_BLINK_EN
         exp_red = (i % 2 == 0);
`else
         exp_red = 1'b1;
`endif
         obs = {Red, Yellow, Green, Busy, Done, Fault};
         n_checks++;
         if (obs !== {exp_red, 5'b00001}) begin
            n_fail++; $display("FAIL fault_hold[%0d]: got %b expected %b", i, obs, {exp_red, 5'b00001});
         end
         tick();
      end
      n_checks++;
      if (False_Start !== 4'b0100) begin
         n_fail++; $display("FAIL fault_flags: got %b expected 0100", False_Start);
      end
      Start = 1'b0;
      Abort = 1'b1; tick(); Abort = 1'b0;
      obs = {Red, Yellow, Green, Busy, Done, Fault};
      n_checks++;
      if (obs !== V_IDLE || False_Start !== 4'b0100) begin
         n_fail++; $display("FAIL fault_abort: got %b/%b expected %b/0100", obs, False_Start, V_IDLE);
      end
      Abort = 1'b1; tick(); Abort = 1'b0;
      obs = {Red, Yellow, Green, Busy, Done, Fault};
      n_checks++;
      if (obs !== V_IDLE || False_Start !== 4'b0100) begin
         n_fail++; $display("FAIL idle_abort: got %b/%b expected %b/0100", obs, False_Start, V_IDLE);
      end
      Start = 1'b1; tick(); Start = 1'b0;
      obs = {Red, Yellow, Green, Busy, Done, Fault};
      n_checks++;
      if (obs !== V_RED || False_Start !== 4'b0000) begin
         n_fail++; $display("FAIL restart_clear: got %b/%b expected %b/0000", obs, False_Start, V_RED);
      end
      // Abort and motion on the same edge: abort wins, flags untouched.
      Abort = 1'b1; Lane_Move = 4'b1111; tick(); Abort = 1'b0; Lane_Move = 4'b0000;
      obs = {Red, Yellow, Green, Busy, Done, Fault};
      n_checks++;
      if (obs !== V_IDLE || False_Start !== 4'b0000) begin
         n_fail++; $display("FAIL abort_vs_lane: got %b/%b expected %b/0000", obs, False_Start, V_IDLE);
      end
   endtask

   task automatic test_grn_motion();
      logic [5:0] obs;
      Start = 1'b1; tick(); Start = 1'b0;
      tick(); tick(); tick(); tick();    // first GRN clock
      Lane_Move = 4'b1111;
      for (int i = 0; i < 6; i++) begin
         obs = {Red, Yellow, Green, Busy, Done, Fault};
         n_checks++;
         if (obs !== V_GRN) begin
            n_fail++; $display("FAIL grn_motion[%0d]: got %b expected %b", i, obs, V_GRN);
         end
         tick();
      end
      Lane_Move = 4'b0000;
      obs = {Red, Yellow, Green, Busy, Done, Fault};
      n_checks++;
      if (obs !== V_DONE || False_Start !== 4'b0000) begin
         n_fail++; $display("FAIL grn_motion_done: got %b/%b expected %b/0000", obs, False_Start, V_DONE);
      end
      tick();
   endtask

   task automatic test_abort_grn();
      logic [5:0] obs;
      Start = 1'b1; tick(); Start = 1'b0;
      for (int i = 0; i < 6; i++) tick(); // third GRN clock
      obs = {Red, Yellow, Green, Busy, Done, Fault};
      n_checks++;
      if (obs !== V_GRN) begin
         n_fail++; $display("FAIL abort_grn_pre: got %b expected %b", obs, V_GRN);
      end
      Abort = 1'b1; tick(); Abort = 1'b0;
      obs = {Red, Yellow, Green, Busy, Done, Fault};
      n_checks++;
      if (obs !== V_IDLE) begin
         n_fail++; $display("FAIL abort_grn: got %b expected %b", obs, V_IDLE);
      end
      tick();
      n_checks++;
      if (Done !== 1'b0) begin
         n_fail++; $display("FAIL abort_grn_nodone: got %b expected 0", Done);
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] obs;
      Start = 1'b1; tick();
      for (int i = 0; i < 10; i++) tick();
      obs = {Red, Yellow, Green, Busy, Done, Fault};
      n_checks++;
      if (obs !== V_DONE) begin
         n_fail++; $display("FAIL b2b_done: got %b expected %b", obs, V_DONE);
      end
      tick();
      obs = {Red, Yellow, Green, Busy, Done, Fault};
      n_checks++;
      if (obs !== V_RED) begin
         n_fail++; $display("FAIL b2b_relaunch: got %b expected %b", obs, V_RED);
      end
      Start = 1'b0;
      Abort = 1'b1; tick(); Abort = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [5:0] obs;
      int busy_cnt;
      Start = 1'b1; tick(); Start = 1'b0;
      tick(); tick();
      obs = {Red, Yellow, Green, Busy, Done, Fault};
      n_checks++;
      if (obs !== V_YEL) begin
         n_fail++; $display("FAIL rst_mid_pre: got %b expected %b", obs, V_YEL);
      end
      nReset = 1'b0; #1;
      obs = {Red, Yellow, Green, Busy, Done, Fault};
      n_checks++;
      if (obs !== V_IDLE) begin
         n_fail++; $display("FAIL rst_mid_async: got %b expected %b", obs, V_IDLE);
      end
      nReset = 1'b1;
      Start = 1'b1; tick(); Start = 1'b0;
      Lane_Move = 4'b0001; tick(); Lane_Move = 4'b0000;
      n_checks++;
      if (False_Start !== 4'b0001 || Fault !== 1'b1) begin
         n_fail++; $display("FAIL rst_fault_pre: got %b/%b expected 0001/1", False_Start, Fault);
      end
      nReset = 1'b0; #1;
      n_checks++;
      if (False_Start !== 4'b0000 || Fault !== 1'b0) begin
         n_fail++; $display("FAIL rst_fault_clear: got %b/%b expected 0000/0", False_Start, Fault);
      end
      nReset = 1'b1;
      busy_cnt = 0;
      Start = 1'b1; tick(); Start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (Busy === 1'b1) busy_cnt++;
         tick();
      end
      obs = {Red, Yellow, Green, Busy, Done, Fault};
      n_checks++;
      if (obs !== V_DONE || busy_cnt != 10) begin
         n_fail++; $display("FAIL rst_resume: got %b busy=%0d expected %b busy=10", obs, busy_cnt, V_DONE);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_params();
      test_normal();
      test_false_start();
      test_grn_motion();
      test_abort_grn();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
